// File: rtl/add16u_err_monitor.sv
// add16u_err_monitor: error-statistics collector for an approximate 16-bit
// unsigned adder. Each accepted (A, B, O) triple is compared against the exact
// sum A+B. Over a window of 2^WIN_LOG2 samples the block gathers the total
// absolute error, the worst-case error and the count of erroneous samples, and
// then presents them through a valid/ready result handshake.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   start       pulse that opens a window (honoured only in IDLE)
//   busy        high while sampling or draining the pipeline
//   in_valid    sample valid
//   in_ready    sample ready (high only while sampling)
//   in_a, in_b  adder operands
//   in_o        approximate adder output for (in_a, in_b)
//   res_valid   window results valid
//   res_ready   result consumer ready
//   sum_abs_err sum of |(A+B) - O| over the window
//   max_err     maximum |(A+B) - O| over the window
//   err_cnt     number of samples with O != A+B
module add16u_err_monitor #(
    parameter int unsigned WIN_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           in_a,
    input  logic [15:0]           in_b,
    input  logic [16:0]           in_o,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [16+WIN_LOG2:0]  sum_abs_err,
    output logic [16:0]           max_err,
    output logic [WIN_LOG2:0]     err_cnt
);

    localparam int unsigned SUM_W = 17 + WIN_LOG2;
    localparam int unsigned CNT_W = WIN_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((64'd1 << WIN_LOG2) - 64'd1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_busy;
    logic               r_in_ready;
    logic               r_res_valid;
    logic               w_busy;
    logic               w_in_ready;
    logic               w_res_valid;

    logic [CNT_W-1:0]   r_cnt;
    logic               r_s1_valid;
    logic [15:0]        r_a;
    logic [15:0]        r_b;
    logic [16:0]        r_o;
    logic [SUM_W-1:0]   r_sum;
    logic [16:0]        r_max;
    logic [CNT_W-1:0]   r_err_cnt;

    logic               w_accept;
    logic               w_clear;
    logic [16:0]        w_exact;
    logic [16:0]        w_err;

    // in_ready is a registered copy of "state is RUN", so accept needs no decode
    assign w_accept = in_valid & r_in_ready;
    assign w_clear  = (r_state == ST_IDLE) && start;

    // State register; handshake flags are registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_busy      <= w_busy;
            r_in_ready  <= w_in_ready;
            r_res_valid <= w_res_valid;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next_state = ST_RUN;
            ST_RUN:    if (w_accept && (r_cnt == LAST_IDX)) w_next_state = ST_DRAIN;
            // Final sample sits in stage 1 for one edge; leave once it is consumed
            ST_DRAIN:  if (!r_s1_valid) w_next_state = ST_REPORT;
            ST_REPORT: if (res_ready) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Output decode from the next state, captured by the state register
    always_comb begin
        w_busy      = 1'b0;
        w_in_ready  = 1'b0;
        w_res_valid = 1'b0;
        case (w_next_state)
            ST_RUN:    begin w_busy = 1'b1; w_in_ready = 1'b1; end
            ST_DRAIN:  w_busy = 1'b1;
            ST_REPORT: w_res_valid = 1'b1;
            default:   ;
        endcase
    end

    // Stage 1: capture the accepted sample and count accepts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_o        <= '0;
        end else begin
            if (w_clear) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_s1_valid <= w_accept & ~w_clear;
            if (w_accept) begin
                r_a <= in_a;
                r_b <= in_b;
                r_o <= in_o;
            end
        end
    end

    // Stage 2: exact sum and absolute error of the stage-1 sample
    assign w_exact = {1'b0, r_a} + {1'b0, r_b};
    assign w_err   = (w_exact >= r_o) ? (w_exact - r_o) : (r_o - w_exact);

    // Accumulators; the sum width covers the worst case so no saturation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum     <= '0;
            r_max     <= '0;
            r_err_cnt <= '0;
        end else if (w_clear) begin
            r_sum     <= '0;
            r_max     <= '0;
            r_err_cnt <= '0;
        end else if (r_s1_valid) begin
            r_sum     <= r_sum + SUM_W'(w_err);
            if (w_err > r_max) begin
                r_max <= w_err;
            end
            r_err_cnt <= r_err_cnt + CNT_W'(w_err != 17'd0);
        end
    end

    assign busy        = r_busy;
    assign in_ready    = r_in_ready;
    assign res_valid   = r_res_valid;
    assign sum_abs_err = r_sum;
    assign max_err     = r_max;
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_add16u_err_monitor.sv
// Self-checking bench for add16u_err_monitor: one instance with a 4-sample
// window driven from a directed vector table plus handshake/reset sequences,
// and one instance with a 1024-sample window fed by an exact adder.
module tb_add16u_err_monitor;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] o;
    } samp_t;

    typedef struct packed {
        logic [18:0] sum;
        logic [16:0] max;
        logic [2:0]  cnt;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start2;
    logic        start10;
    logic        in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [16:0] in_o;
    logic        res_ready;

    logic        busy2, in_ready2, res_valid2;
    logic [18:0] sum2;
    logic [16:0] max2;
    logic [2:0]  cnt2;

    logic        busy10, in_ready10, res_valid10;
    logic [26:0] sum10;
    logic [16:0] max10;
    logic [10:0] cnt10;

    int n_checks = 0;
    int n_pass   = 0;

    samp_t vec  [4][4];
    res_t  want [4];

    always #5 clk = ~clk;

    add16u_err_monitor #(.WIN_LOG2(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_o(in_o),
        .res_valid(res_valid2), .res_ready(res_ready),
        .sum_abs_err(sum2), .max_err(max2), .err_cnt(cnt2)
    );

    add16u_err_monitor #(.WIN_LOG2(10)) dut10 (
        .clk(clk), .rst(rst), .start(start10), .busy(busy10),
        .in_valid(in_valid), .in_ready(in_ready10),
        .in_a(in_a), .in_b(in_b), .in_o(in_o),
        .res_valid(res_valid10), .res_ready(res_ready),
        .sum_abs_err(sum10), .max_err(max10), .err_cnt(cnt10)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    endtask

    // One 4-sample window from the table, optionally with stray start pulses
    task automatic apply_win(input int idx, input bit pulse_run, input bit pulse_rep);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("start_busy", 64'(busy2), 64'd1);
        chk("start_rdy", 64'(in_ready2), 64'd1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_a     = vec[idx][i].a;
            in_b     = vec[idx][i].b;
            in_o     = vec[idx][i].o;
            start2   = pulse_run && (i == 2);
            tick();
        end
        in_valid = 1'b0;
        start2   = 1'b0;
        chk("rdy_drop", 64'(in_ready2), 64'd0);
        chk("rv_k", 64'(res_valid2), 64'd0);
        tick();
        chk("rv_k1", 64'(res_valid2), 64'd0);
        chk("busy_k1", 64'(busy2), 64'd1);
        tick();
        chk("rv_k2", 64'(res_valid2), 64'd1);
        chk("busy_k2", 64'(busy2), 64'd0);
        if (pulse_rep) begin
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            chk("rep_start_rv", 64'(res_valid2), 64'd1);
        end
        chk("win_sum", 64'(sum2), 64'(want[idx].sum));
        chk("win_max", 64'(max2), 64'(want[idx].max));
        chk("win_cnt", 64'(cnt2), 64'(want[idx].cnt));
        // start coincident with the REPORT->IDLE edge must be ignored
        res_ready = 1'b1;
        start2    = 1'b1;
        tick();
        res_ready = 1'b0;
        start2    = 1'b0;
        chk("rel_rv", 64'(res_valid2), 64'd0);
        tick();
        chk("rel_busy", 64'(busy2), 64'd0);
        chk("idle_hold_sum", 64'(sum2), 64'(want[idx].sum));
    endtask

    initial begin
        int accepts;
        int m_sum, m_max, m_cnt, d;
        int waited;

        vec[0][0] = '{16'd1,      16'd2,      17'd8};
        vec[0][1] = '{16'd100,    16'd200,    17'd305};
        vec[0][2] = '{16'h1000,   16'h2000,   17'h03005};
        vec[0][3] = '{16'd0,      16'd0,      17'd5};
        want[0]   = '{19'd20, 17'd5, 3'd4};
        vec[1][0] = '{16'hFFFF,   16'hFFFF,   17'd0};
        vec[1][1] = '{16'd1,      16'd2,      17'd3};
        vec[1][2] = '{16'd1,      16'd2,      17'd3};
        vec[1][3] = '{16'd1,      16'd2,      17'd3};
        want[1]   = '{19'd131070, 17'd131070, 3'd1};
        vec[2][0] = '{16'd10,     16'd20,     17'd25};
        vec[2][1] = '{16'd100,    16'd0,      17'd110};
        vec[2][2] = '{16'd0,      16'd0,      17'd0};
        vec[2][3] = '{16'hFFFF,   16'd1,      17'h10000};
        want[2]   = '{19'd15, 17'd10, 3'd2};
        vec[3][0] = '{16'h8000,   16'h8000,   17'h1FFFF};
        vec[3][1] = '{16'd5,      16'd5,      17'd9};
        vec[3][2] = '{16'd3,      16'd3,      17'd6};
        vec[3][3] = '{16'd0,      16'd1,      17'd0};
        want[3]   = '{19'd65537, 17'd65535, 3'd3};

        rst = 1'b1; start2 = 1'b0; start10 = 1'b0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_o = '0; res_ready = 1'b0;
        tick(); tick(); tick();
        chk("rst_busy", 64'(busy2), 64'd0);
        chk("rst_rdy", 64'(in_ready2), 64'd0);
        chk("rst_rv", 64'(res_valid2), 64'd0);
        chk("rst_sum", 64'(sum2), 64'd0);
        chk("rst_max", 64'(max2), 64'd0);
        chk("rst_cnt", 64'(cnt2), 64'd0);
        chk("rst_busy10", 64'(busy10), 64'd0);
        rst = 1'b0;
        tick();

        // Directed windows from the table
        for (int w = 0; w < 4; w++) apply_win(w, 1'b0, 1'b0);
        // Stray starts in RUN and REPORT must not disturb the result
        apply_win(2, 1'b1, 1'b1);

        // Random in_valid handshake with a reference model
        accepts = 0; m_sum = 0; m_max = 0; m_cnt = 0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int c = 0; c < 200 && accepts < 4; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a     = 16'($urandom);
            in_b     = 16'($urandom);
            in_o     = ({1'b0, in_a} + {1'b0, in_b}) ^ 17'($urandom_range(0, 3));
            if (in_valid && in_ready2) begin
                accepts++;
                d = (int'(in_a) + int'(in_b)) - int'(in_o);
                if (d < 0) d = -d;
                m_sum += d;
                if (d > m_max) m_max = d;
                if (d != 0) m_cnt++;
            end
            tick();
        end
        chk("hs_accepts", 64'(accepts), 64'd4);
        chk("hs_rdy_drop", 64'(in_ready2), 64'd0);
        // A 5th sample offered with a huge error must never be captured
        in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF; in_o = 17'd0;
        waited = 0;
        while (!res_valid2 && waited < 10) begin
            chk("hs_no_rdy", 64'(in_ready2), 64'd0);
            tick();
            waited++;
        end
        chk("hs_rv", 64'(res_valid2), 64'd1);
        for (int h = 0; h < 5; h++) begin
            chk("hs_hold_rv", 64'(res_valid2), 64'd1);
            chk("hs_hold_sum", 64'(sum2), 64'(m_sum));
            chk("hs_hold_max", 64'(max2), 64'(m_max));
            chk("hs_hold_cnt", 64'(cnt2), 64'(m_cnt));
            tick();
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("hs_rel_rv", 64'(res_valid2), 64'd0);

        // Reset mid-window, with start held during reset
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_a = vec[1][i].a; in_b = vec[1][i].b; in_o = vec[1][i].o;
            tick();
        end
        in_valid = 1'b0;
        tick();
        rst = 1'b1; start2 = 1'b1;
        tick();
        chk("mid_rst_busy", 64'(busy2), 64'd0);
        chk("mid_rst_rdy", 64'(in_ready2), 64'd0);
        chk("mid_rst_rv", 64'(res_valid2), 64'd0);
        chk("mid_rst_sum", 64'(sum2), 64'd0);
        chk("mid_rst_max", 64'(max2), 64'd0);
        chk("mid_rst_cnt", 64'(cnt2), 64'd0);
        tick();
        chk("rst_start_ign", 64'(busy2), 64'd0);
        rst = 1'b0; start2 = 1'b0;
        tick();
        chk("post_rst_idle", 64'(busy2), 64'd0);
        apply_win(0, 1'b0, 1'b0);

        // Exact adder over a 1024-sample window
        start10 = 1'b1;
        tick();
        start10 = 1'b0;
        chk("w10_busy", 64'(busy10), 64'd1);
        for (int i = 0; i < 1024; i++) begin
            if (!in_ready10) chk("w10_rdy_run", 64'(in_ready10), 64'd1);
            in_valid = 1'b1;
            in_a = 16'($urandom);
            in_b = 16'($urandom);
            in_o = {1'b0, in_a} + {1'b0, in_b};
            tick();
        end
        in_valid = 1'b0;
        chk("w10_rdy_drop", 64'(in_ready10), 64'd0);
        chk("w10_rv_k", 64'(res_valid10), 64'd0);
        tick();
        chk("w10_rv_k1", 64'(res_valid10), 64'd0);
        tick();
        chk("w10_rv_k2", 64'(res_valid10), 64'd1);
        chk("w10_sum", 64'(sum10), 64'd0);
        chk("w10_max", 64'(max10), 64'd0);
        chk("w10_cnt", 64'(cnt10), 64'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("w10_rel_rv", 64'(res_valid10), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/add16u_err_monitor.md
# add16u_err_monitor

Sequential error-statistics collector that sits directly downstream of an approximate 16-bit unsigned adder (17-bit result). It accepts a stream of operand/result triples (A, B, approximate O) and recomputes the exact sum A+B for each one. Over a window of 2^WIN_LOG2 samples it accumulates the total absolute error, the worst-case error and the number of erroneous samples, then presents them through a result handshake. It is the on-chip counterpart of the MAE/WCE/EP figures in each adder's header.

## Interface
- WIN_LOG2, default 10: log2 of samples per window; legal range 1..16.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle pulse; starts a window, honoured only in IDLE.
- busy  out  1  high in RUN and DRAIN.
- in_valid  in  1  sample-valid.
- in_ready  out  1  sample-ready; high only in RUN.
- in_a  in  16  operand A.
- in_b  in  16  operand B.
- in_o  in  17  approximate adder output O for (in_a, in_b).
- res_valid  out  1  results valid; high only in REPORT.
- res_ready  in  1  result consumer ready.
- sum_abs_err  out  17+WIN_LOG2  sum of |(A+B) − O| over the window.
- max_err  out  17  maximum |(A+B) − O| over the window.
- err_cnt  out  WIN_LOG2+1  count of samples with O ≠ A+B.

## Operation
- FSM states: IDLE, RUN, DRAIN, REPORT. Reset state is IDLE.
- IDLE:
  - start=1 clears the accumulators, the sample counter and the pipeline valid bit, then moves to RUN.
  - start in any other state is ignored.
- RUN:
  - A sample is accepted on an edge where in_valid & in_ready.
  - When the accept count reaches 2^WIN_LOG2, in_ready drops the following cycle and the FSM moves to DRAIN.
  - No sample beyond 2^WIN_LOG2 is ever accepted.
- DRAIN: waits until the final sample has been accumulated, then moves to REPORT.
- REPORT:
  - res_valid=1; outputs are held stable until an edge with res_ready=1.
  - On that edge the FSM returns to IDLE.
  - Outputs keep their final values in IDLE until the next start clears them.
- Stage 1 registers in_a, in_b, in_o and a valid bit on accept.
- Stage 2 computes the exact sum as a 17-bit zero-extended A+B, and the error as |exact − O|, 17 bits unsigned (max 131071).
- On the edge after stage 1 is loaded with a valid sample:
  - sum_abs_err += err.
  - max_err = max(max_err, err).
  - err_cnt += (err ≠ 0).
- Width rules:
  - The sum cannot overflow: 2^16 samples × 131071 fits in 17+16 bits. No saturation logic.
  - err_cnt reaches at most 2^WIN_LOG2, which is why it is WIN_LOG2+1 bits wide.
- in_valid while in_ready=0 is ignored; data is not captured.
- rst at any time, including mid-window or in REPORT, aborts the window. The block returns to IDLE with every output at its reset value.

## Timing
- Reset values:
  - busy=0, in_ready=0, res_valid=0.
  - sum_abs_err=0, max_err=0, err_cnt=0.
- start sampled at edge t: in_ready=1 and busy=1 from cycle t+1.
- Latency: the final sample is accepted at edge k and accumulated at edge k+1. res_valid=1 from the cycle after edge k+2, when busy falls.
- Minimum window length is 2^WIN_LOG2 + 3 cycles from start to res_valid, with in_valid held high.
- Throughput: one sample per cycle; no bubbles are inserted by the block.
- res_valid & res_ready at edge r: res_valid=0 from cycle r+1.
- A start pulse in the same cycle as the REPORT→IDLE edge is ignored; start must arrive in IDLE.

## Test plan
- Exact adder, WIN_LOG2=10:
  - Drive 1024 random samples with in_o = in_a+in_b and in_valid held high.
  - Expect sum_abs_err=0, max_err=0, err_cnt=0.
  - Expect res_valid exactly 3 cycles after the final accept.
- Constant bias, WIN_LOG2=2:
  - Drive 4 samples with O = A+B+5.
  - Expect sum_abs_err=20, max_err=5, err_cnt=4.
- Worst case, WIN_LOG2=2:
  - Samples: (0xFFFF, 0xFFFF, O=0); then (1, 2, O=3) three times.
  - Expect sum_abs_err=131070, max_err=131070, err_cnt=1.
- Handshake, WIN_LOG2=2:
  - Toggle in_valid randomly; hold res_ready=0 for 5 cycles in REPORT.
  - Expect exactly 4 accepts, in_ready=0 after the 4th, outputs stable while res_valid=1.
  - A 5th in_valid is not captured.
- Reset mid-window:
  - Assert rst after 2 of 4 samples.
  - Expect IDLE, all outputs 0, and start ignored while rst=1.
  - A new window after that produces correct results.
- start during RUN and REPORT: ignored; counters are not cleared and the result matches a window run without the extra pulse.
